// File: rtl/physics_raster.sv
// Renders up to N_PART particles into a GRID x GRID pixel matrix, one pixel per clock, on a period tick or refresh.
// Frames are double-buffered: matrix changes only at COMMIT, GRID*GRID+1 edges after the start edge.
module physics_raster #(
  parameter int N_PART       = 4,
  parameter int GRID         = 16,
  parameter int COORD_W      = 16,
  parameter int FRAC         = 4,
  parameter int RADIUS_SQ    = 1,
  parameter int FRAME_CYCLES = 10000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PART*COORD_W-1:0]   pos_x,
  input  logic [N_PART*COORD_W-1:0]   pos_y,
  input  logic [N_PART-1:0]           part_en,
  input  logic                        refresh,
  output logic [GRID*GRID-1:0]        matrix,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        overrun
);

  localparam int NPIX = GRID * GRID;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW   = (GRID > 1) ? $clog2(GRID) : 1;
  localparam int CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int SW   = 2 * COORD_W + 3;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [IW-1:0]               idx_q;
  logic [PW-1:0]               px_q, py_q;
  logic [N_PART*COORD_W-1:0]   sx_q, sy_q;
  logic [N_PART-1:0]           en_q;
  logic [NPIX-1:0]             back_q, matrix_q;
  logic                        done_q, overrun_q;

  logic                        tick, start_req, lit_d;
  logic signed [COORD_W-1:0]   cx, cy;
  logic signed [COORD_W:0]     px_s, py_s, dx, dy;
  logic signed [2*COORD_W+1:0] dxe, dye, sqx, sqy;
  logic [SW-1:0]               dist_sq;

  assign tick      = (cnt_q == CW'(FRAME_CYCLES - 1));
  assign start_req = tick | refresh;

  // Distance test for the current scan pixel against every snapshotted particle.
  always_comb begin
    lit_d   = 1'b0;
    cx      = '0;
    cy      = '0;
    dx      = '0;
    dy      = '0;
    dxe     = '0;
    dye     = '0;
    sqx     = '0;
    sqy     = '0;
    dist_sq = '0;
    px_s    = $signed({{(COORD_W+1-PW){1'b0}}, px_q});
    py_s    = $signed({{(COORD_W+1-PW){1'b0}}, py_q});
    for (int i = 0; i < N_PART; i++) begin
      cx      = $signed(sx_q[i*COORD_W +: COORD_W]) >>> FRAC;
      cy      = $signed(sy_q[i*COORD_W +: COORD_W]) >>> FRAC;
      dx      = px_s - $signed({cx[COORD_W-1], cx});
      dy      = py_s - $signed({cy[COORD_W-1], cy});
      dxe     = {{(COORD_W+1){dx[COORD_W]}}, dx};
      dye     = {{(COORD_W+1){dy[COORD_W]}}, dy};
      sqx     = dxe * dxe;
      sqy     = dye * dye;
      dist_sq = {1'b0, sqx} + {1'b0, sqy};
      if (en_q[i] && (dist_sq <= SW'(RADIUS_SQ))) lit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      en_q      <= '0;
      back_q    <= '0;
      matrix_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + CW'(1);
      done_q <= 1'b0;
      if (start_req && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_req) begin
            sx_q    <= pos_x;
            sy_q    <= pos_y;
            en_q    <= part_en;
            idx_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          back_q[idx_q] <= lit_d;
          if (idx_q == IW'(NPIX - 1)) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + IW'(1);
            if (px_q == PW'(GRID - 1)) begin
              px_q <= '0;
              py_q <= py_q + PW'(1);
            end else begin
              px_q <= px_q + PW'(1);
            end
          end
        end
        COMMIT: begin
          matrix_q <= back_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign matrix     = matrix_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule
